// File: rtl/logi_io_ctrl.sv
// -----------------------------------------------------------------------------
// logi_io_ctrl
// Switch/LED front end between the board pins and the core logic.
//  - Each raw switch pin is passed through a 2-flop synchroniser and then
//    debounced with its own counter. The outputs are the clean level
//    (sw_state), one-cycle rise/fall pulses and sticky rise flags.
//  - Each LED has its own selectable mode:
//    direct, blink, shared-duty PWM, or switch mirror.
//    Every LED output is registered.
// Ports:
//  clk        system clock
//  rst_n      asynchronous active-low reset
//  sw_in      raw switch pins (asynchronous to clk)
//  sw_state   debounced switch level
//  sw_rise    1-cycle pulse on debounced 0->1
//  sw_fall    1-cycle pulse on debounced 1->0
//  evt_flags  sticky rise flags
//  evt_clr    per-bit clear for evt_flags (a set in the same cycle wins)
//  led_data   LED data for modes 00/01
//  led_mode   mode of LED i = led_mode[2i+1:2i]
//  led_duty   shared PWM duty (unsigned compare against the PWM counter)
//  led_out    registered LED drive
// -----------------------------------------------------------------------------
module logi_io_ctrl #(
    parameter int N_SW    = 8,
    parameter int N_LED   = 8,
    parameter int DEB_W   = 16,
    parameter int DEB_CNT = 16000,
    parameter int PWM_W   = 8,
    parameter int BLINK_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SW-1:0]      sw_in,
    output logic [N_SW-1:0]      sw_state,
    output logic [N_SW-1:0]      sw_rise,
    output logic [N_SW-1:0]      sw_fall,
    output logic [N_SW-1:0]      evt_flags,
    input  logic [N_SW-1:0]      evt_clr,
    input  logic [N_LED-1:0]     led_data,
    input  logic [2*N_LED-1:0]   led_mode,
    input  logic [PWM_W-1:0]     led_duty,
    output logic [N_LED-1:0]     led_out
);

    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CNT - 1);
    localparam logic [DEB_W-1:0]   DEB_ONE   = DEB_W'(1);
    localparam logic [PWM_W-1:0]   PWM_ONE   = PWM_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);

    logic [N_SW-1:0]    s1_q, s2_q;
    logic [DEB_W-1:0]   cnt_q [N_SW];
    logic [DEB_W-1:0]   cnt_d [N_SW];
    logic [N_SW-1:0]    state_q, state_d;
    logic [N_SW-1:0]    rise_q, fall_q, flags_q;
    logic [PWM_W-1:0]   pwm_q;
    logic [BLINK_W-1:0] blink_q;
    logic [N_LED-1:0]   led_q, led_d;
    // Zero-padded copy of sw_state so mirror mode on LEDs beyond N_SW reads 0.
    logic [N_LED+N_SW-1:0] mirror_s;
    logic                  blink_s;
    logic                  pwm_on_s;

    // Debounce next state: accept s2 only after DEB_CNT consecutive mismatching cycles.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] != state_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    state_d[i] = s2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i]   = cnt_q[i] + DEB_ONE;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    assign mirror_s = {{N_LED{1'b0}}, state_q};
    assign blink_s  = blink_q[BLINK_W-1];
    assign pwm_on_s = (pwm_q < led_duty);

    // LED mode multiplexer; the result is registered into led_q.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_LED; i++) begin
            case (led_mode[2*i +: 2])
                2'b00:   led_d[i] = led_data[i];
                2'b01:   led_d[i] = led_data[i] & blink_s;
                2'b10:   led_d[i] = pwm_on_s;
                2'b11:   led_d[i] = mirror_s[i];
                default: led_d[i] = 1'b0;
            endcase
        end
    end

    // Synchroniser, debounce, edge pulses and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            state_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            flags_q <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= sw_in;
            s2_q    <= s1_q;
            state_q <= state_d;
            // Pulses are computed from the next state, so each one lines up
            // with the first cycle in which sw_state shows the new level.
            rise_q  <= state_d & ~state_q;
            fall_q  <= ~state_d & state_q;
            // Setting the flag has priority over a clear in the same cycle.
            flags_q <= (flags_q & ~evt_clr) | rise_q;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Free-running PWM and blink counters plus the registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q   <= '0;
            blink_q <= '0;
            led_q   <= '0;
        end else begin
            pwm_q   <= pwm_q + PWM_ONE;
            blink_q <= blink_q + BLINK_ONE;
            led_q   <= led_d;
        end
    end

    assign sw_state  = state_q;
    assign sw_rise   = rise_q;
    assign sw_fall   = fall_q;
    assign evt_flags = flags_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_logi_io_ctrl.sv
module tb_logi_io_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sw_in;
    logic [7:0]  sw_state, sw_rise, sw_fall, evt_flags, evt_clr;
    logic [9:0]  led_data;
    logic [19:0] led_mode;
    logic [3:0]  led_duty;
    logic [9:0]  led_out;

    int n_assert = 0;
    int n_fail   = 0;

    logi_io_ctrl #(
        .N_SW(8), .N_LED(10), .DEB_W(4), .DEB_CNT(4), .PWM_W(4), .BLINK_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
        .sw_state(sw_state), .sw_rise(sw_rise), .sw_fall(sw_fall),
        .evt_flags(evt_flags), .evt_clr(evt_clr),
        .led_data(led_data), .led_mode(led_mode), .led_duty(led_duty),
        .led_out(led_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int cnt;
        int bad;
        logic smp [16];

        // Reset with every switch held high.
        rst_n = 1'b0; sw_in = 8'hFF; evt_clr = 8'h00;
        led_data = 10'h000; led_mode = 20'h00000; led_duty = 4'h0;
        ticks(3);
        chk("rst_state", 32'(sw_state), 32'h0);
        chk("rst_flags", 32'(evt_flags), 32'h0);
        chk("rst_led",   32'(led_out), 32'h0);

        // T1: release; edges 0..4 show 0, edge 5 shows FF and the rise pulse.
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (sw_state !== 8'h00 || sw_rise !== 8'h00) bad++;
        end
        chk("t1_hold_zero", 32'(bad), 32'h0);
        tick();
        chk("t1_state", 32'(sw_state), 32'hFF);
        chk("t1_rise",  32'(sw_rise), 32'hFF);
        chk("t1_flag_before", 32'(evt_flags), 32'h00);
        tick();
        chk("t1_rise_end", 32'(sw_rise), 32'h00);
        chk("t1_flags", 32'(evt_flags), 32'hFF);

        // Clear all flags.
        evt_clr = 8'hFF; tick(); evt_clr = 8'h00;
        chk("clr_all", 32'(evt_flags), 32'h00);

        // Drop bit 0; fall pulse on edge 5.
        sw_in = 8'hFE;
        ticks(5);
        chk("fall_wait", 32'(sw_state), 32'hFF);
        tick();
        chk("fall_state", 32'(sw_state), 32'hFE);
        chk("fall_pulse", 32'(sw_fall), 32'h01);
        ticks(3);

        // T2: bounce bit 0 every 3 cycles for 30 cycles; nothing must change.
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            sw_in[0] = ((k / 3) % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            if (sw_state[0] !== 1'b0 || sw_rise[0] !== 1'b0 || sw_fall[0] !== 1'b0) bad++;
        end
        chk("t2_bounce", 32'(bad), 32'h0);
        sw_in[0] = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (sw_state[0] !== 1'b0) bad++;
        end
        chk("t2_hold_wait", 32'(bad), 32'h0);
        tick();
        chk("t2_state", 32'(sw_state), 32'hFF);
        chk("t2_rise",  32'(sw_rise), 32'h01);

        // T3: drop bit 1, clear flags, then raise it with a racing clear.
        sw_in = 8'hFD;
        ticks(8);
        chk("t3_low", 32'(sw_state), 32'hFD);
        evt_clr = 8'hFF; tick(); evt_clr = 8'h00;
        chk("t3_clr", 32'(evt_flags), 32'h00);
        sw_in = 8'hFF;
        ticks(6);
        chk("t3_rise", 32'(sw_rise), 32'h02);
        evt_clr = 8'h02;
        tick();
        chk("t3_set_wins", 32'(evt_flags), 32'h02);
        tick();
        chk("t3_cleared", 32'(evt_flags), 32'h00);
        evt_clr = 8'h00;

        // Mode 00: direct drive with one-cycle latency.
        led_mode = 20'h00000; led_data = 10'h2A5;
        tick();
        chk("direct", 32'(led_out), 32'h2A5);
        led_data = 10'h15A;
        tick();
        chk("direct2", 32'(led_out), 32'h15A);

        // T4: PWM on LED 0, other LEDs direct with data 0.
        led_data = 10'h000; led_mode = 20'h00002;
        led_duty = 4'd4; ticks(2);
        cnt = 0; bad = 0;
        for (int k = 0; k < 16; k++) begin
            tick(); cnt += int'(led_out[0]);
            if (led_out[9:1] !== 9'h000) bad++;
        end
        chk("pwm_duty4", 32'(cnt), 32'd4);
        chk("pwm_others", 32'(bad), 32'd0);
        led_duty = 4'd0; ticks(2);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin tick(); cnt += int'(led_out[0]); end
        chk("pwm_duty0", 32'(cnt), 32'd0);
        led_duty = 4'd15; ticks(2);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin tick(); cnt += int'(led_out[0]); end
        chk("pwm_duty15", 32'(cnt), 32'd15);

        // T5: blink on LED 0, period-8 square wave.
        led_mode = 20'h00001; led_data = 10'h001; ticks(2);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin tick(); smp[k] = led_out[0]; cnt += int'(led_out[0]); end
        bad = 0;
        for (int k = 0; k < 12; k++) if (smp[k] === smp[k+4]) bad++;
        chk("blink_count", 32'(cnt), 32'd8);
        chk("blink_shape", 32'(bad), 32'd0);
        led_data = 10'h000; ticks(2);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin tick(); cnt += int'(led_out[0]); end
        chk("blink_off", 32'(cnt), 32'd0);

        // T6: mirror mode on all LEDs.
        led_mode = 20'hFFFFF;
        tick();
        chk("mirror_ff", 32'(led_out), 32'h0FF);
        sw_in = 8'hA5;
        ticks(6);
        chk("mirror_state", 32'(sw_state), 32'hA5);
        chk("mirror_lag", 32'(led_out), 32'h0FF);
        tick();
        chk("mirror_a5", 32'(led_out), 32'h0A5);

        // Mid-run asynchronous reset, observed before the next clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", 32'(sw_state), 32'h0);
        chk("async_flags", 32'(evt_flags), 32'h0);
        chk("async_pulses", 32'({sw_rise, sw_fall}), 32'h0);
        chk("async_led", 32'(led_out), 32'h0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
